// File: rtl/skinny_masked_pkg.sv
// Shared types and constants for the serial masked Skinny-64 datapath.
// The S-box constant is packed so that SKINNY_SBOX[x] is the image of nibble x.
package skinny_masked_pkg;
    localparam int SECURITY_ORDER = 4;
    localparam int NIBBLES        = 16;
    localparam int SBOX_LATENCY   = 8;
    localparam int FRESH_W        = 170;
    localparam int STATE_W        = 64;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} sched_state_t;

    localparam logic [15:0][3:0] SKINNY_SBOX = 64'hF7E4D583B2A1096C;

    // Nibble n of one 64-bit share.
    function automatic logic [3:0] share_nibble(input logic [STATE_W-1:0] share,
                                                input int unsigned n);
        return share[4*n +: 4];
    endfunction
endpackage

// File: rtl/sbox_wait_counter.sv
// Loadable down-counter that times the fixed S-box core latency.
// It saturates at zero so a late decrement never wraps.
module sbox_wait_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);
    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec && cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);
endmodule

// File: rtl/skinny_sbox_layer_sched.sv
// Time-shares one masked S-box core over all nibbles of a (d+1)-share state.
// Core inputs are held in registers so they stay stable for the whole latency window.
module skinny_sbox_layer_sched
    import skinny_masked_pkg::*;
#(
    parameter int SECURITY_ORDER = skinny_masked_pkg::SECURITY_ORDER,
    parameter int NIBBLES        = skinny_masked_pkg::NIBBLES,
    parameter int SBOX_LATENCY   = skinny_masked_pkg::SBOX_LATENCY,
    parameter int FRESH_W        = skinny_masked_pkg::FRESH_W
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [(SECURITY_ORDER+1)*64-1:0] state_in,
    input  logic                             rnd_valid,
    input  logic [FRESH_W-1:0]               rnd_in,
    output logic                             rnd_ready,
    output logic [(SECURITY_ORDER+1)*4-1:0]  sbox_in,
    output logic [FRESH_W-1:0]               sbox_fresh,
    input  logic [(SECURITY_ORDER+1)*4-1:0]  sbox_out,
    output logic [(SECURITY_ORDER+1)*64-1:0] state_out,
    output logic                             busy,
    output logic                             done
);
    localparam int SHARES = SECURITY_ORDER + 1;
    localparam int CW     = (SBOX_LATENCY > 1) ? $clog2(SBOX_LATENCY) : 1;
    localparam int NW     = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    sched_state_t         state, state_nx;
    logic [SHARES*64-1:0] work, result;
    logic [NW-1:0]        n;
    logic [SHARES*4-1:0]  issue_nib;
    logic                 issue_fire, capture, last, cnt_zero;

    sbox_wait_counter #(.W(CW)) u_wait_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (issue_fire),
        .load_val (CW'(SBOX_LATENCY - 1)),
        .dec      (state == WAIT),
        .zero     (cnt_zero)
    );

    assign last = (n == NW'(NIBBLES - 1));

    always_comb begin
        issue_nib = '0;
        for (int s = 0; s < SHARES; s++)
            issue_nib[s*4 +: 4] = share_nibble(work[s*64 +: 64], int'(n));
    end

    always_comb begin
        state_nx   = state;
        issue_fire = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE:  if (start) state_nx = ISSUE;
            ISSUE: if (rnd_valid) begin
                issue_fire = 1'b1;
                state_nx   = WAIT;
            end
            WAIT:  if (cnt_zero) begin
                capture  = 1'b1;
                state_nx = last ? DONE : ISSUE;
            end
            DONE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            work       <= '0;
            result     <= '0;
            n          <= '0;
            sbox_in    <= '0;
            sbox_fresh <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start) begin
                work <= state_in;
                n    <= '0;
            end
            // Fresh randomness is taken once per nibble, never reused.
            if (issue_fire) begin
                sbox_in    <= issue_nib;
                sbox_fresh <= rnd_in;
            end else if (state == DONE) begin
                sbox_in    <= '0;
                sbox_fresh <= '0;
            end
            if (capture) begin
                for (int s = 0; s < SHARES; s++)
                    result[s*64 + 4*int'(n) +: 4] <= sbox_out[s*4 +: 4];
                if (!last)
                    n <= n + 1'b1;
            end
        end
    end

    assign rnd_ready = issue_fire;
    assign busy      = (state == ISSUE) || (state == WAIT);
    assign done      = (state == DONE);
    assign state_out = result;
endmodule

// File: tb/tb_skinny_sbox_layer_sched.sv
// Directed bench: a behavioural masked S-box core drives sbox_out, table vectors
// cover full runs, hand sequences cover reset state and reset mid-run.
module tb_skinny_sbox_layer_sched;
    import skinny_masked_pkg::*;

    localparam int D  = 4;
    localparam int SH = D + 1;
    localparam int SW = SH * 64;

    logic              clk = 1'b0;
    logic              rst, start, rnd_valid;
    logic [SW-1:0]     state_in, state_out;
    logic [FRESH_W-1:0] rnd_in, sbox_fresh;
    logic              rnd_ready, busy, done;
    logic [SH*4-1:0]   sbox_in, sbox_out;

    always #5 clk = ~clk;

    skinny_sbox_layer_sched dut (
        .clk(clk), .rst(rst), .start(start), .state_in(state_in),
        .rnd_valid(rnd_valid), .rnd_in(rnd_in), .rnd_ready(rnd_ready),
        .sbox_in(sbox_in), .sbox_fresh(sbox_fresh), .sbox_out(sbox_out),
        .state_out(state_out), .busy(busy), .done(done)
    );

    // Core model: recombine input, apply S-box, re-share using fresh bits.
    always_comb begin
        logic [3:0] x, acc;
        x = '0;
        for (int s = 0; s < SH; s++) x ^= sbox_in[s*4 +: 4];
        acc = SKINNY_SBOX[x];
        sbox_out = '0;
        for (int s = 1; s < SH; s++) begin
            sbox_out[s*4 +: 4] = sbox_fresh[(s-1)*4 +: 4];
            acc ^= sbox_fresh[(s-1)*4 +: 4];
        end
        sbox_out[3:0] = acc;
    end

    typedef struct {
        logic [63:0] plain;
        bit          rand_shares;
        int          stall_at;
        int          stall_len;
        int          start_a;
        int          start_b;
        logic [63:0] exp;
        int          exp_done;
    } vec_t;

    int n_vec = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic new_rnd();
        logic [191:0] t;
        for (int i = 0; i < 6; i++) t[i*32 +: 32] = $urandom;
        rnd_in = t[FRESH_W-1:0];
    endtask

    function automatic logic [SW-1:0] make_shares(input logic [63:0] p, input bit rnd);
        logic [SW-1:0] st;
        logic [63:0]   acc;
        st  = '0;
        acc = p;
        if (rnd)
            for (int s = 1; s < SH; s++) begin
                st[s*64 +: 64] = {$urandom, $urandom};
                acc ^= st[s*64 +: 64];
            end
        st[63:0] = acc;
        return st;
    endfunction

    function automatic logic [63:0] unshare(input logic [SW-1:0] st);
        logic [63:0] acc;
        acc = '0;
        for (int s = 0; s < SH; s++) acc ^= st[s*64 +: 64];
        return acc;
    endfunction

    // One full run; start is high during cycle 0, outputs sampled #1 after the negedge.
    task automatic run_vec(input vec_t v, input string tag);
        int cyc, done_cyc, nready, viol, extra_done;
        logic [SH*4-1:0]    prev_in;
        logic [FRESH_W-1:0] prev_fr;
        logic [SW-1:0]      res;
        bit prev_issue, prev_done, got, unstable;
        @(negedge clk);
        cyc = 0; done_cyc = -1; nready = 0; viol = 0; extra_done = 0; got = 0;
        start = 1'b1; state_in = make_shares(v.plain, v.rand_shares);
        rnd_valid = 1'b1; new_rnd();
        #1;
        prev_in = sbox_in; prev_fr = sbox_fresh; prev_issue = 0; prev_done = 0;
        while (!got && cyc < 400) begin
            @(posedge clk); cyc++;
            @(negedge clk);
            start     = (cyc == v.start_a) || (cyc == v.start_b);
            rnd_valid = !(cyc >= v.stall_at && cyc < v.stall_at + v.stall_len);
            new_rnd();
            #1;
            if ((sbox_in !== prev_in || sbox_fresh !== prev_fr) && !prev_issue && !prev_done)
                viol++;
            prev_in = sbox_in; prev_fr = sbox_fresh;
            prev_issue = rnd_ready; prev_done = done;
            if (rnd_ready) nready++;
            if (done) begin got = 1; done_cyc = cyc; res = state_out; end
        end
        chk({tag, "_done_cycle"}, 64'(done_cyc), 64'(v.exp_done));
        chk({tag, "_result"}, unshare(state_out), v.exp);
        chk({tag, "_rnd_ready_count"}, 64'(nready), 64'd16);
        chk({tag, "_core_input_stable"}, 64'(viol), 64'd0);
        unstable = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); cyc++;
            @(negedge clk);
            start = (cyc == v.start_a) || (cyc == v.start_b);
            #1;
            if (k == 0) chk({tag, "_core_cleared"}, 64'({sbox_in, sbox_fresh} != '0), 64'd0);
            if (done) extra_done++;
            if (busy || state_out !== res) unstable = 1;
        end
        start = 1'b0;
        chk({tag, "_single_done"}, 64'(extra_done), 64'd0);
        chk({tag, "_idle_after"}, 64'(unstable), 64'd0);
    endtask

    vec_t vecs[5];

    initial begin
        vecs[0] = '{64'hFEDCBA9876543210, 1'b0, -1, 0, -1, -1, 64'hF7E4D583B2A1096C, 145};
        vecs[1] = '{64'h0123456789ABCDEF, 1'b1, -1, 0, -1, -1, 64'hC6901A2B385D4E7F, 145};
        vecs[2] = '{64'h0000000000000000, 1'b1, -1, 0, -1, -1, 64'hCCCCCCCCCCCCCCCC, 145};
        vecs[3] = '{64'hFEDCBA9876543210, 1'b1, 28, 5, -1, -1, 64'hF7E4D583B2A1096C, 150};
        vecs[4] = '{64'h0123456789ABCDEF, 1'b1, -1, 0, 10, 145, 64'hC6901A2B385D4E7F, 145};

        rst = 1'b1; start = 1'b0; rnd_valid = 1'b1; state_in = '0; rnd_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk("reset_outputs", 64'({busy, done, rnd_ready, sbox_in, sbox_fresh, state_out} != '0), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Reset mid-run: rst high during cycle 60, cycle 61 must be idle and cleared.
        begin
            int cyc, dn;
            @(negedge clk);
            start = 1'b1; state_in = make_shares(64'h0123456789ABCDEF, 1'b1); rnd_valid = 1'b1;
            cyc = 0; dn = 0;
            while (cyc < 61) begin
                @(posedge clk); cyc++;
                @(negedge clk);
                start = 1'b0; rst = (cyc == 60); new_rnd();
                #1;
                if (done) dn++;
            end
            chk("midreset_no_done", 64'(dn), 64'd0);
            chk("midreset_outputs",
                64'({busy, done, rnd_ready, sbox_in, sbox_fresh, state_out} != '0), 64'd0);
            rst = 1'b0;
        end
        run_vec('{64'hFEDCBA9876543210, 1'b1, -1, 0, -1, -1, 64'hF7E4D583B2A1096C, 145}, "after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
